// File: rtl/mem_responder_if.sv
// Core-to-memory request/response bundle used by mem_responder.
// master = core side, slave = memory responder side.
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic        fetch;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic        mem_complete;
    logic [31:0] rdata;
    logic        error;

    modport master (
        output mem_read, mem_write, fetch, addr, f3, wdata,
        input  mem_complete, rdata, error
    );

    modport slave (
        input  mem_read, mem_write, fetch, addr, f3, wdata,
        output mem_complete, rdata, error
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: byte/half/word accesses on an internal word RAM,
// fixed wait-state latency, one-cycle completion pulse with error flag.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int unsigned WORD_W = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH  = 1 << WORD_W;
    localparam logic [3:0]  WS_M1  = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic                mem_complete_q;
    logic [31:0]         rdata_q;
    logic                error_q;
    logic [WORD_W-1:0]   word_q;
    logic [1:0]          lane_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic                wr_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;

    logic [31:0]         mem_q [DEPTH];

    // Decode of the request currently presented on the bus
    logic                req_c;
    logic [1:0]          size_d;
    logic                uns_d;
    logic                illegal_d;
    logic                misalign_d;
    logic                range_d;
    logic                err_d;
    logic [WORD_W-1:0]   word_d;
    logic [1:0]          lane_d;
    logic [3:0]          be_d;
    logic [31:0]         wshift_d;

    always_comb begin
        req_c      = bus.mem_read | bus.mem_write;
        size_d     = bus.fetch ? 2'd2 : bus.f3[1:0];
        uns_d      = ~bus.fetch & bus.f3[2];
        illegal_d  = ~bus.fetch & ((bus.f3[1:0] == 2'b11) | (bus.f3[2] & bus.f3[1]) |
                                   (bus.f3[2] & bus.mem_write));
        misalign_d = ((size_d == 2'd1) & bus.addr[0]) |
                     ((size_d == 2'd2) & (|bus.addr[1:0]));
        range_d    = |(bus.addr >> ADDR_WIDTH);
        err_d      = illegal_d | misalign_d | range_d;
        word_d     = bus.addr[ADDR_WIDTH-1:2];
        lane_d     = bus.addr[1:0];
        wshift_d   = bus.wdata << {lane_d, 3'b000};
        case (size_d)
            2'd0:    be_d = 4'b0001 << lane_d;
            2'd1:    be_d = 4'b0011 << lane_d;
            default: be_d = 4'b1111;
        endcase
    end

    // Extract the addressed lane and sign/zero extend it
    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] lane,
                                        input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = w >> {lane, 3'b000};
        case (size)
            2'd0:    fmt = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    fmt = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: fmt = w;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            mem_complete_q <= 1'b0;
            rdata_q        <= 32'd0;
            error_q        <= 1'b0;
            word_q         <= '0;
            lane_q         <= 2'd0;
            size_q         <= 2'd0;
            uns_q          <= 1'b0;
            wr_q           <= 1'b0;
            be_q           <= 4'd0;
            wdata_q        <= 32'd0;
        end else begin
            mem_complete_q <= 1'b0;
            error_q        <= 1'b0;
            rdata_q        <= 32'd0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_c) begin
                        word_q  <= word_d;
                        lane_q  <= lane_d;
                        size_q  <= size_d;
                        uns_q   <= uns_d;
                        wr_q    <= bus.mem_write;
                        be_q    <= be_d;
                        wdata_q <= wshift_d;
                        if (err_d) begin
                            state_q        <= S_RESP;
                            mem_complete_q <= 1'b1;
                            error_q        <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            state_q        <= S_RESP;
                            mem_complete_q <= 1'b1;
                            rdata_q        <= bus.mem_write ? 32'd0 :
                                              fmt(mem_q[word_d], lane_d, size_d, uns_d);
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WS_M1;
                        end
                    end
                end
                S_WAIT: begin
                    // Core withdrew the request: abandon silently
                    if (!req_c) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q        <= S_RESP;
                        mem_complete_q <= 1'b1;
                        rdata_q        <= wr_q ? 32'd0 :
                                          fmt(mem_q[word_q], lane_q, size_q, uns_q);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Store commits at the end of RESP only if the core still holds mem_write
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && wr_q && !error_q && bus.mem_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem_q[word_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign bus.mem_complete = mem_complete_q;
    assign bus.rdata        = rdata_q;
    assign bus.error        = error_q;

endmodule
